grom_alu: RTL and testbench
===========================

Name: grom_alu

Overview:
- Clocked 8-bit ALU for the grom 8-bit CPU datapath.
- The CPU presents operand A (normally R0), operand B (a register) and an opcode, then writes back the registered result one cycle later.
- The block keeps the architectural carry flag C, used by ADC/SBC/RCL/RCR, plus the zero flag Z and sign flag S.

Parameters:
- WIDTH, 8, data width of A, B and result. Examples below assume 8; the MSB is WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  operation strobe; state updates only on a clk edge with en=1.
- A  input  WIDTH  first operand (accumulator).
- B  input  WIDTH  second operand.
- operation  input  5  opcode.
- result  output  WIDTH  registered result.
- C  output  1  registered carry/borrow flag.
- Z  output  1  registered zero flag.
- S  output  1  registered sign flag (result MSB).

Behaviour:
- Reset (reset=0, asynchronous): result=0, C=0, Z=0, S=0, and V=0 when present. Release is synchronous to the next edge.
- en=0: result and all flags hold.
- en=1 at a clk edge: the opcode is evaluated combinationally on the current A, B and C. result and flags are registered, so they are valid one cycle after the strobe.
- Back-to-back strobes are allowed; ADC/SBC/RCL/RCR use the C produced by the previous op.
- Unless stated otherwise below: Z = (new result == 0), S = new result[7].
- Opcodes (C rule in brackets):
  - 00000 ADD: A+B [C=carry out].
  - 00001 SUB: A-B [C=borrow, 1 iff A<B unsigned].
  - 00010 ADC: A+B+C [C=carry out].
  - 00011 SBC: A-B-C [C=borrow].
  - 00100 AND: A&B [C=0].
  - 00101 OR: A|B [C=0].
  - 00110 NOT: ~B [C=0].
  - 00111 XOR: A^B [C=0].
  - 01000 INC: B+1 [C unchanged].
  - 01001 DEC: B-1 [C unchanged].
  - 01010 CMP: result=A unchanged. C/Z/S are set exactly as for SUB of A-B.
  - 01011 TST: result=A unchanged. Z/S are from A&B; C=0.
  - 01100-01111: reserved; result=A, flags unchanged.
  - 10000 SHL: {A[6:0],0} [C=A[7]].
  - 10001 SHR: {0,A[7:1]} [C=A[0]].
  - 10010 SAL: identical to SHL.
  - 10011 SAR: {A[7],A[7:1]} [C=A[0]].
  - 10100 ROL: {A[6:0],A[7]} [C=A[7]].
  - 10101 ROR: {A[0],A[7:1]} [C=A[0]].
  - 10110 RCL: {A[6:0],C} [C=A[7]].
  - 10111 RCR: {C,A[7:1]} [C=A[0]].
  - 11000-11111: reserved; result=A, flags unchanged.
- Wrap-around: all arithmetic is modulo 256. Examples: INC 0xFF -> 0x00, Z=1; DEC 0x00 -> 0xFF, S=1.
- Reset asserted mid-sequence clears everything immediately, regardless of en.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined: adds output port V (1 bit, registered, reset 0).
  - Set to signed two's-complement overflow on ADD, SUB, ADC, SBC, CMP, INC, DEC.
  - Cleared on logic ops, TST and shifts.
  - Unchanged on reserved opcodes.
- Undefined: no V port and no V logic; all other behaviour identical.

Test Plan:
- Reset low with arbitrary inputs -> result=0x00, C=Z=S=0. Release, then en=1, ADD A=0x7F B=0x01 -> next cycle result=0x80, S=1, C=0, Z=0 (V=1 if enabled).
- ADD A=0xFF B=0x01 -> result=0x00, C=1, Z=1; then ADC A=0x00 B=0x00 -> result=0x01, C=0.
- SUB A=0x10 B=0x20 -> result=0xF0, C=1, S=1; then CMP A=0x05 B=0x05 -> result=0x05, Z=1, C=0.
- RCR A=0x01 with C=1 -> result=0x80, C=1; then SAR A=0x81 -> result=0xC0, C=1.
- INC B=0xFF with C=1 -> result=0x00, Z=1, C stays 1; then TST A=0xF0 B=0x0F -> result=0xF0, Z=1, C=0.
- en=0 for several cycles with changing A/B/operation -> outputs hold. Assert reset between two strobes -> outputs clear at once.

Source files
------------

// File: rtl/grom_alu.sv
// Clocked WIDTH-bit ALU for the grom CPU: registered result plus architectural C/Z/S flags.
// Optional signed-overflow flag V is built when ALU_OVERFLOW_EN is defined.
module grom_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             C,
  output logic             Z,
  output logic             S
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int MSB = WIDTH - 1;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_ADC = 5'b00010;
  localparam logic [4:0] OP_SBC = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00101;
  localparam logic [4:0] OP_NOT = 5'b00110;
  localparam logic [4:0] OP_XOR = 5'b00111;
  localparam logic [4:0] OP_INC = 5'b01000;
  localparam logic [4:0] OP_DEC = 5'b01001;
  localparam logic [4:0] OP_CMP = 5'b01010;
  localparam logic [4:0] OP_TST = 5'b01011;
  localparam logic [4:0] OP_SHL = 5'b10000;
  localparam logic [4:0] OP_SHR = 5'b10001;
  localparam logic [4:0] OP_SAL = 5'b10010;
  localparam logic [4:0] OP_SAR = 5'b10011;
  localparam logic [4:0] OP_ROL = 5'b10100;
  localparam logic [4:0] OP_ROR = 5'b10101;
  localparam logic [4:0] OP_RCL = 5'b10110;
  localparam logic [4:0] OP_RCR = 5'b10111;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] result_r;
  logic             c_r, z_r, s_r;
  logic [WIDTH-1:0] res_s, alt_s, flag_val_s;
  logic             c_s, upd_s, alt_sel_s;
  logic [WIDTH:0]   sum_s, diff_s, adc_s, sbc_s;
  logic [WIDTH-1:0] inc_s, dec_s;

  // Extra top bit of each adder is the carry (add) or borrow (subtract).
  always_comb begin
    sum_s  = {1'b0, A} + {1'b0, B};
    diff_s = {1'b0, A} - {1'b0, B};
    adc_s  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, c_r};
    sbc_s  = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, c_r};
    inc_s  = B + ONE_W;
    dec_s  = B - ONE_W;
  end

  // Opcode decode; CMP/TST take Z/S from alt_s instead of the written result.
  always_comb begin
    res_s     = A;
    alt_s     = A;
    alt_sel_s = 1'b0;
    c_s       = c_r;
    upd_s     = 1'b1;
    case (operation)
      OP_ADD: begin res_s = sum_s[MSB:0];  c_s = sum_s[WIDTH];  end
      OP_SUB: begin res_s = diff_s[MSB:0]; c_s = diff_s[WIDTH]; end
      OP_ADC: begin res_s = adc_s[MSB:0];  c_s = adc_s[WIDTH];  end
      OP_SBC: begin res_s = sbc_s[MSB:0];  c_s = sbc_s[WIDTH];  end
      OP_AND: begin res_s = A & B; c_s = 1'b0; end
      OP_OR:  begin res_s = A | B; c_s = 1'b0; end
      OP_NOT: begin res_s = ~B;    c_s = 1'b0; end
      OP_XOR: begin res_s = A ^ B; c_s = 1'b0; end
      OP_INC: res_s = inc_s;
      OP_DEC: res_s = dec_s;
      OP_CMP: begin alt_s = diff_s[MSB:0]; alt_sel_s = 1'b1; c_s = diff_s[WIDTH]; end
      OP_TST: begin alt_s = A & B; alt_sel_s = 1'b1; c_s = 1'b0; end
      OP_SHL, OP_SAL: begin res_s = {A[MSB-1:0], 1'b0}; c_s = A[MSB]; end
      OP_SHR: begin res_s = {1'b0, A[MSB:1]};   c_s = A[0];   end
      OP_SAR: begin res_s = {A[MSB], A[MSB:1]}; c_s = A[0];   end
      OP_ROL: begin res_s = {A[MSB-1:0], A[MSB]}; c_s = A[MSB]; end
      OP_ROR: begin res_s = {A[0], A[MSB:1]};   c_s = A[0];   end
      OP_RCL: begin res_s = {A[MSB-1:0], c_r};  c_s = A[MSB]; end
      OP_RCR: begin res_s = {c_r, A[MSB:1]};    c_s = A[0];   end
      default: upd_s = 1'b0;
    endcase
    if (alt_sel_s) begin
      flag_val_s = alt_s;
    end else begin
      flag_val_s = res_s;
    end
  end

  // Result and flag registers; reserved opcodes leave the flags alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_r <= {WIDTH{1'b0}};
      c_r      <= 1'b0;
      z_r      <= 1'b0;
      s_r      <= 1'b0;
    end else if (en) begin
      result_r <= res_s;
      if (upd_s) begin
        c_r <= c_s;
        z_r <= (flag_val_s == {WIDTH{1'b0}});
        s_r <= flag_val_s[MSB];
      end
    end
  end

  assign result = result_r;
  assign C      = c_r;
  assign Z      = z_r;
  assign S      = s_r;

`ifdef ALU_OVERFLOW_EN
  logic v_r, v_s;

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow for arithmetic ops; logic/shift ops clear it.
  always_comb begin
    v_s = 1'b0;
    case (operation)
      OP_ADD: v_s = add_ovf(A[MSB], B[MSB], sum_s[MSB]);
      OP_SUB, OP_CMP: v_s = sub_ovf(A[MSB], B[MSB], diff_s[MSB]);
      OP_ADC: v_s = add_ovf(A[MSB], B[MSB], adc_s[MSB]);
      OP_SBC: v_s = sub_ovf(A[MSB], B[MSB], sbc_s[MSB]);
      OP_INC: v_s = add_ovf(B[MSB], 1'b0, inc_s[MSB]);
      OP_DEC: v_s = sub_ovf(B[MSB], 1'b0, dec_s[MSB]);
      default: v_s = 1'b0;
    endcase
  end

  // Overflow flag register, gated like the other flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_r <= 1'b0;
    end else if (en && upd_s) begin
      v_r <= v_s;
    end
  end

  assign V = v_r;
`endif

endmodule

// File: tb/tb_grom_alu.sv
// Self-checking bench for grom_alu: directed plan steps then random ops against an integer model.
module tb_grom_alu;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic [4:0] operation = 5'd0;
  logic [7:0] result;
  logic       C, Z, S;
`ifdef ALU_OVERFLOW_EN
  logic       V;
`endif

  grom_alu #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .en(en), .A(A), .B(B), .operation(operation),
    .result(result), .C(C), .Z(Z), .S(S)
`ifdef ALU_OVERFLOW_EN
    , .V(V)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int m_res = 0;
  int m_c = 0, m_z = 0, m_s = 0, m_v = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".result"}, {24'd0, result}, m_res);
    chk({tag, ".C"}, {31'd0, C}, m_c);
    chk({tag, ".Z"}, {31'd0, Z}, m_z);
    chk({tag, ".S"}, {31'd0, S}, m_s);
`ifdef ALU_OVERFLOW_EN
    chk({tag, ".V"}, {31'd0, V}, m_v);
`endif
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic int ovf(input int t);
    return (t > 127 || t < -128) ? 1 : 0;
  endfunction

  // Reference model: integer arithmetic straight from the opcode table.
  task automatic model(input int op, input int a, input int b);
    int t, r, fv, c, v, upd;
    c = m_c; v = m_v; upd = 1; fv = -1; r = a;
    case (op)
      0:  begin t = a + b; r = t % 256; c = (t > 255); v = ovf(sgn(a) + sgn(b)); end
      1:  begin r = (a - b + 256) % 256; c = (a < b); v = ovf(sgn(a) - sgn(b)); end
      2:  begin t = a + b + m_c; r = t % 256; c = (t > 255); v = ovf(sgn(a) + sgn(b) + m_c); end
      3:  begin t = a - b - m_c; r = (t + 512) % 256; c = (t < 0); v = ovf(sgn(a) - sgn(b) - m_c); end
      4:  begin r = a & b; c = 0; v = 0; end
      5:  begin r = a | b; c = 0; v = 0; end
      6:  begin r = 255 - b; c = 0; v = 0; end
      7:  begin r = a ^ b; c = 0; v = 0; end
      8:  begin r = (b + 1) % 256; v = ovf(sgn(b) + 1); end
      9:  begin r = (b + 255) % 256; v = ovf(sgn(b) - 1); end
      10: begin r = a; fv = (a - b + 256) % 256; c = (a < b); v = ovf(sgn(a) - sgn(b)); end
      11: begin r = a; fv = a & b; c = 0; v = 0; end
      16, 18: begin r = (a * 2) % 256; c = a / 128; v = 0; end
      17: begin r = a / 2; c = a % 2; v = 0; end
      19: begin r = a / 2 + ((a >= 128) ? 128 : 0); c = a % 2; v = 0; end
      20: begin r = (a * 2) % 256 + a / 128; c = a / 128; v = 0; end
      21: begin r = a / 2 + (a % 2) * 128; c = a % 2; v = 0; end
      22: begin r = (a * 2) % 256 + m_c; c = a / 128; v = 0; end
      23: begin r = a / 2 + m_c * 128; c = a % 2; v = 0; end
      default: upd = 0;
    endcase
    if (fv < 0) fv = r;
    m_res = r;
    if (upd != 0) begin
      m_c = c; m_v = v;
      m_z = (fv == 0) ? 1 : 0;
      m_s = (fv >= 128) ? 1 : 0;
    end
  endtask

  task automatic step(input int op, input int a, input int b, input logic e, input string tag);
    @(negedge clk);
    operation = op[4:0]; A = a[7:0]; B = b[7:0]; en = e;
    @(posedge clk);
    if (e) model(op, a, b);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_res = 0; m_c = 0; m_z = 0; m_s = 0; m_v = 0;
  endtask

  initial begin
    // Reset held with arbitrary inputs and en active.
    A = 8'hA5; B = 8'h3C; operation = 5'd7; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk) reset = 1'b1;

    step(0, 8'h7F, 8'h01, 1'b1, "add_7f_01");
    chk("add_7f_01.lit", {24'd0, result}, 32'h80);
    step(0, 8'hFF, 8'h01, 1'b1, "add_ff_01");
    chk("add_ff_01.litC", {31'd0, C}, 32'd1);
    step(2, 8'h00, 8'h00, 1'b1, "adc_carry");
    chk("adc_carry.lit", {24'd0, result}, 32'h01);
    step(1, 8'h10, 8'h20, 1'b1, "sub_borrow");
    chk("sub_borrow.lit", {24'd0, result}, 32'hF0);
    step(10, 8'h05, 8'h05, 1'b1, "cmp_eq");
    chk("cmp_eq.litZ", {31'd0, Z}, 32'd1);
    step(1, 8'h00, 8'h01, 1'b1, "sub_setc");
    step(23, 8'h01, 8'h00, 1'b1, "rcr_c1");
    chk("rcr_c1.lit", {24'd0, result}, 32'h80);
    step(19, 8'h81, 8'h00, 1'b1, "sar_81");
    chk("sar_81.lit", {24'd0, result}, 32'hC0);
    step(8, 8'h33, 8'hFF, 1'b1, "inc_ff");
    chk("inc_ff.litC", {31'd0, C}, 32'd1);
    step(9, 8'h00, 8'h00, 1'b1, "dec_00");
    step(11, 8'hF0, 8'h0F, 1'b1, "tst_f0_0f");
    chk("tst_f0_0f.lit", {24'd0, result}, 32'hF0);
    step(3, 8'h00, 8'hFF, 1'b1, "sbc_wrap");
    step(12, 8'h5A, 8'h00, 1'b1, "reserved_0c");
    step(27, 8'h00, 8'h11, 1'b1, "reserved_1b");

    // en low: everything must hold while inputs churn.
    for (int i = 0; i < 4; i++) begin
      step($urandom_range(0, 31), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, "hold");
    end

    // Reset between two strobes clears immediately.
    step(0, 8'h80, 8'h80, 1'b1, "pre_reset");
    @(negedge clk);
    en = 1'b1; reset = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk) reset = 1'b1;
    step(16, 8'hC3, 8'h00, 1'b1, "post_reset_shl");

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 31), $urandom_range(0, 255), $urandom_range(0, 255),
           ($urandom_range(0, 3) != 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
